// File: rtl/dmem_arbiter.sv
// Two-port arbiter onto single-port Dmem: core (C) and external loader (E), bounded bursts, E starvation override.
// Grant one cycle after a request seen in IDLE; read data one cycle after a granted load; core_stall while C waits.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4,
  parameter int MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic [DW-1:0] c_rdata,
  output logic          c_rvalid,
  output logic          core_stall,
  input  logic          e_req,
  input  logic          e_we,
  input  logic [AW-1:0] e_addr,
  input  logic [DW-1:0] e_wdata,
  output logic          e_gnt,
  output logic [DW-1:0] e_rdata,
  output logic          e_rvalid,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);
  localparam logic [WW-1:0] WAIT_SAT   = WW'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, OWN_C, OWN_E} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] burst_cnt;
  logic [WW-1:0] wait_cnt;
  logic          e_urgent;
  logic          burst_done;

  assign e_urgent   = e_req && (wait_cnt >= WAIT_SAT);
  assign burst_done = (burst_cnt == BURST_LAST);

  assign c_gnt      = (state == OWN_C) && c_req;
  assign e_gnt      = (state == OWN_E) && e_req;
  assign core_stall = c_req && !c_gnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (e_urgent)   state_nxt = OWN_E;
        else if (c_req) state_nxt = OWN_C;
        else if (e_req) state_nxt = OWN_E;
        else            state_nxt = IDLE;
      end
      OWN_C: begin
        // A long-waiting E preempts C even mid-burst.
        if (e_urgent)                          state_nxt = OWN_E;
        else if (c_req && !(e_req && burst_done)) state_nxt = OWN_C;
        else if (e_req)                        state_nxt = OWN_E;
        else                                   state_nxt = IDLE;
      end
      OWN_E: begin
        if (e_req && !(c_req && burst_done)) state_nxt = OWN_E;
        else if (c_req)                      state_nxt = OWN_C;
        else                                 state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    if (c_gnt) begin
      m_we    = c_we;
      m_addr  = c_addr;
      m_wdata = c_wdata;
    end else if (e_gnt) begin
      m_we    = e_we;
      m_addr  = e_addr;
      m_wdata = e_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      state <= state_nxt;
      // Saturates so a long solo burst yields after one more beat once the other side asks.
      if (state == IDLE || state_nxt != state)
        burst_cnt <= '0;
      else if ((c_gnt || e_gnt) && !burst_done)
        burst_cnt <= burst_cnt + 1'b1;
      if (!e_req || e_gnt)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_SAT)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_rvalid <= 1'b0;
      e_rvalid <= 1'b0;
      c_rdata  <= '0;
      e_rdata  <= '0;
    end else begin
      c_rvalid <= c_gnt && !c_we;
      e_rvalid <= e_gnt && !e_we;
      if (c_gnt && !c_we) c_rdata <= m_rdata;
      if (e_gnt && !e_we) e_rdata <= m_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected read data queued at load grant, popped on rvalid.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        c_req, c_we, e_req, e_we;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata;
  logic        c_gnt, c_rvalid, core_stall, e_gnt, e_rvalid, m_we;
  logic [31:0] c_rdata, e_rdata, m_addr, m_wdata, m_rdata;

  logic        c_req2, e_req2;
  logic        c_gnt2, c_rvalid2, core_stall2, e_gnt2, e_rvalid2, m_we2;
  logic [31:0] c_rdata2, e_rdata2, m_addr2, m_wdata2;

  logic [31:0] mem [0:63];
  logic [31:0] cq[$];
  logic [31:0] eq[$];
  int total = 0;
  int bad   = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rdata(c_rdata), .c_rvalid(c_rvalid), .core_stall(core_stall),
    .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata),
    .e_gnt(e_gnt), .e_rdata(e_rdata), .e_rvalid(e_rvalid),
    .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  dmem_arbiter #(.BURST_MAX(16), .MAX_WAIT(8)) dut16 (
    .clk(clk), .rst(rst),
    .c_req(c_req2), .c_we(1'b0), .c_addr(32'd0), .c_wdata(32'd0),
    .c_gnt(c_gnt2), .c_rdata(c_rdata2), .c_rvalid(c_rvalid2), .core_stall(core_stall2),
    .e_req(e_req2), .e_we(1'b0), .e_addr(32'd4), .e_wdata(32'd0),
    .e_gnt(e_gnt2), .e_rdata(e_rdata2), .e_rvalid(e_rvalid2),
    .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2), .m_rdata(32'd0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_rdata = mem[m_addr[7:2]];
  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

  // Read-data monitor: every rvalid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    logic [31:0] exp_v;
    if (c_rvalid) begin
      total++;
      if (cq.size() == 0) begin
        bad++;
        $display("FAIL c_read_unexpected got=%h want=none", c_rdata);
      end else begin
        exp_v = cq.pop_front();
        if (c_rdata !== exp_v) begin
          bad++;
          $display("FAIL c_rdata got=%h want=%h", c_rdata, exp_v);
        end
      end
    end
    if (e_rvalid) begin
      total++;
      if (eq.size() == 0) begin
        bad++;
        $display("FAIL e_read_unexpected got=%h want=none", e_rdata);
      end else begin
        exp_v = eq.pop_front();
        if (e_rdata !== exp_v) begin
          bad++;
          $display("FAIL e_rdata got=%h want=%h", e_rdata, exp_v);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    e_req = 0; e_we = 0; e_addr = 0; e_wdata = 0;
    c_req2 = 0; e_req2 = 0;
  endtask

  task automatic test_reset();
    logic [31:0] pre;
    rst = 0;
    idle_inputs();
    repeat (2) step();
    rst = 1;
    #2;
    total++;
    if ({c_gnt, e_gnt, c_rvalid, e_rvalid, core_stall, m_we, m_addr, m_wdata, c_rdata, e_rdata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {c_gnt, e_gnt, c_rvalid, e_rvalid, core_stall, m_we, m_addr, m_wdata, c_rdata, e_rdata});
    end
    step();
    pre = mem[6];
    c_req = 1; c_we = 1; c_addr = 24; c_wdata = 32'h55;
    step();
    #1;
    total++;
    if ({c_gnt, m_we} !== 2'b11) begin
      bad++; $display("FAIL reset_pre_beat got=%b want=11", {c_gnt, m_we});
    end
    #1 rst = 0;
    #1;
    total++;
    if ({c_gnt, m_we, m_addr} !== '0) begin
      bad++; $display("FAIL reset_cancel got=%h want=0", {c_gnt, m_we, m_addr});
    end
    step();
    total++;
    if (mem[6] !== pre) begin
      bad++; $display("FAIL reset_no_write got=%h want=%h", mem[6], pre);
    end
    idle_inputs();
    rst = 1;
    #2;
    total++;
    if ({c_gnt, e_gnt, c_rvalid, e_rvalid, core_stall, m_we, m_addr, m_wdata} !== '0) begin
      bad++; $display("FAIL reset_release got=%h want=0",
                      {c_gnt, e_gnt, c_rvalid, e_rvalid, core_stall, m_we, m_addr, m_wdata});
    end
    step();
  endtask

  task automatic test_c_alone();
    c_req = 1; c_we = 1; c_addr = 24; c_wdata = 17;
    #2;
    total++;
    if ({c_gnt, core_stall} !== 2'b01) begin
      bad++; $display("FAIL c_first_wait got=%b want=01", {c_gnt, core_stall});
    end
    step();
    #1;
    total++;
    if ({c_gnt, e_gnt, m_we, m_addr, m_wdata} !== {3'b101, 32'd24, 32'd17}) begin
      bad++; $display("FAIL c_store_beat got=%h want=%h",
                      {c_gnt, e_gnt, m_we, m_addr, m_wdata}, {3'b101, 32'd24, 32'd17});
    end
    step();
    c_we = 0;
    cq.push_back(32'd17);
    #1;
    total++;
    if ({c_gnt, e_gnt, m_we, core_stall} !== 4'b1000) begin
      bad++; $display("FAIL c_load_beat got=%b want=1000", {c_gnt, e_gnt, m_we, core_stall});
    end
    step();
    c_req = 0;
    #1;
    total++;
    if (c_rvalid !== 1'b1) begin
      bad++; $display("FAIL c_rvalid_pulse got=%b want=1", c_rvalid);
    end
    step();
    total++;
    if ({c_rvalid, c_rdata} !== {1'b0, 32'd17}) begin
      bad++; $display("FAIL c_rvalid_drop got=%h want=%h", {c_rvalid, c_rdata}, {1'b0, 32'd17});
    end
    idle_inputs();
    step();
  endtask

  task automatic test_simultaneous();
    logic cg, eg;
    c_req = 1; c_we = 1; c_addr = 40; c_wdata = 1;
    e_req = 1; e_we = 1; e_addr = 44; e_wdata = 2;
    for (int i = 0; i < 13; i++) begin
      cg = (i >= 1 && i <= 4) || (i >= 9);
      eg = (i >= 5 && i <= 8);
      #2;
      total++;
      if ({c_gnt, e_gnt, core_stall} !== {cg, eg, ~cg}) begin
        bad++; $display("FAIL simul_cycle%0d got=%b want=%b", i, {c_gnt, e_gnt, core_stall}, {cg, eg, ~cg});
      end
      step();
    end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_starvation();
    c_req2 = 1;
    repeat (3) step();
    e_req2 = 1;
    for (int k = 0; k < 10; k++) begin
      #2;
      total++;
      if ({c_gnt2, e_gnt2, core_stall2} !== {k < 9, k == 9, k == 9}) begin
        bad++; $display("FAIL starve_cycle%0d got=%b want=%b", k,
                        {c_gnt2, e_gnt2, core_stall2}, {k < 9, k == 9, k == 9});
      end
      step();
    end
    idle_inputs();
    repeat (2) step();
  endtask

  task automatic test_preload();
    e_req = 1; e_we = 1; e_addr = 8; e_wdata = 5;
    #2;
    total++;
    if (e_gnt !== 1'b0) begin
      bad++; $display("FAIL e_first_wait got=%b want=0", e_gnt);
    end
    step();
    #1;
    total++;
    if ({e_gnt, c_gnt, m_we, m_addr} !== {3'b101, 32'd8}) begin
      bad++; $display("FAIL e_write8 got=%h want=%h", {e_gnt, c_gnt, m_we, m_addr}, {3'b101, 32'd8});
    end
    step();
    e_addr = 12; e_wdata = 12;
    #1;
    total++;
    if ({e_gnt, m_we, m_addr, m_wdata} !== {2'b11, 32'd12, 32'd12}) begin
      bad++; $display("FAIL e_write12 got=%h want=%h", {e_gnt, m_we, m_addr, m_wdata}, {2'b11, 32'd12, 32'd12});
    end
    step();
    e_req = 0; e_we = 0;
    c_req = 1; c_we = 0; c_addr = 8;
    #1;
    total++;
    if ({c_gnt, core_stall} !== 2'b01) begin
      bad++; $display("FAIL c_after_e_wait got=%b want=01", {c_gnt, core_stall});
    end
    step();
    cq.push_back(32'd5);
    #1;
    total++;
    if ({c_gnt, m_addr} !== {1'b1, 32'd8}) begin
      bad++; $display("FAIL c_load8 got=%h want=%h", {c_gnt, m_addr}, {1'b1, 32'd8});
    end
    step();
    c_addr = 12;
    cq.push_back(32'd12);
    step();
    c_req = 0;
    step();
    total++;
    if (c_rvalid !== 1'b0) begin
      bad++; $display("FAIL c_load_pulse_end got=%b want=0", c_rvalid);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_release();
    e_req = 1; e_we = 0; e_addr = 12;
    step();
    eq.push_back(32'd12);
    #1;
    total++;
    if (e_gnt !== 1'b1) begin
      bad++; $display("FAIL e_load_gnt got=%b want=1", e_gnt);
    end
    step();
    e_req = 0;
    #1;
    total++;
    if ({e_gnt, e_rvalid} !== 2'b01) begin
      bad++; $display("FAIL e_release got=%b want=01", {e_gnt, e_rvalid});
    end
    step();
    c_req = 1; c_we = 0; c_addr = 8;
    #1;
    total++;
    if ({c_gnt, core_stall} !== 2'b01) begin
      bad++; $display("FAIL idle_regrant_wait got=%b want=01", {c_gnt, core_stall});
    end
    step();
    cq.push_back(32'd5);
    #1;
    total++;
    if (c_gnt !== 1'b1) begin
      bad++; $display("FAIL idle_regrant got=%b want=1", c_gnt);
    end
    step();
    idle_inputs();
    repeat (3) step();
  endtask

  initial begin
    test_reset();
    test_c_alone();
    test_simultaneous();
    test_starvation();
    test_preload();
    test_release();
    total++;
    if (cq.size() != 0 || eq.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", cq.size(), eq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store port (C) and an external loader/debug port (E), e.g. preloading Dmem words before the core runs.
- Sits between the datapath and Dmem.
- Grants one owner per cycle and muxes the address, write data and write enable onto the memory port.
- Returns read data with one cycle of latency; drives a stall to the core while C waits.

Parameters:
AW, 32, address width (byte address, passed through unchanged)
DW, 32, data width
BURST_MAX, 4, max consecutive granted beats per owner while the other side is requesting
MAX_WAIT, 8, E wait cycles after which E preempts C priority

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
c_req  input  1  core access request, held until granted
c_we  input  1  core write enable (1=store, 0=load)
c_addr  input  AW  core address
c_wdata  input  DW  core store data
c_gnt  output  1  core beat accepted this cycle
c_rdata  output  DW  core read data, valid when c_rvalid
c_rvalid  output  1  core read data valid (cycle after granted load)
core_stall  output  1  c_req & ~c_gnt
e_req  input  1  external request, held until granted
e_we  input  1  external write enable
e_addr  input  AW  external address
e_wdata  input  DW  external write data
e_gnt  output  1  external beat accepted
e_rdata  output  DW  external read data
e_rvalid  output  1  external read data valid
m_we  output  1  Dmem write enable
m_addr  output  AW  Dmem address
m_wdata  output  DW  Dmem write data
m_rdata  input  DW  Dmem combinational read data for m_addr

Behaviour:
- Reset (rst=0, async): state=IDLE, burst_cnt=0, wait_cnt=0; c_rvalid=e_rvalid=0; c_rdata=e_rdata=0; c_gnt=e_gnt=0; m_we=0, m_addr=0, m_wdata=0. Reset mid-transfer cancels the beat immediately; no write is issued.
- States: IDLE, OWN_C, OWN_E (registered).
- Grant is combinational from state: c_gnt = (state==OWN_C)&c_req; e_gnt = (state==OWN_E)&e_req. At most one grant per cycle.
- Memory mux:
  - c_gnt: m_addr/m_wdata/m_we come from the C port.
  - e_gnt: they come from the E port.
  - Neither: all zero, m_we=0.
- Beat: a granted cycle is one transfer; a write commits at that rising edge.
- Load data: on a granted load, m_rdata is registered into x_rdata at the edge; x_rvalid=1 for exactly the next cycle, then 0. x_rdata holds its value until the next granted load.
- Next-owner selection (evaluated every edge): pick C if c_req, else E if e_req, else IDLE. Override: if e_req && wait_cnt>=MAX_WAIT, pick E.
- In IDLE: go to the picked owner. The first grant comes one cycle after the request is seen in IDLE.
- In OWN_X, stay if X req=1 and not (other req=1 && burst_cnt==BURST_MAX-1). Otherwise switch directly to the other side if it requests (no dead cycle), else IDLE.
- burst_cnt: increments per granted beat in the same ownership; resets to 0 on an ownership change or IDLE.
- wait_cnt: increments each cycle e_req=1 && ~e_gnt, saturating at MAX_WAIT; clears when E is granted or e_req=0.
- E requests are never starved: bounded by max(BURST_MAX, MAX_WAIT)+1 cycles.
- Addresses pass unchanged; no alignment checking.

Test Plan:
- Reset: assert rst=0 mid-beat with c_req=1, c_we=1, addr 24 -> c_gnt/m_we drop at once, mem[24] unchanged; after release state=IDLE and all outputs 0.
- C alone: C store 17 to addr 24, then load addr 24 -> C granted the cycle after the request; c_rvalid=1 one cycle after the load grant with c_rdata=17; e_gnt stays 0.
- Simultaneous: c_req=e_req=1 from IDLE -> C owns for 4 beats (BURST_MAX). Then E gets 4 beats with no idle cycle between, then back to C; core_stall=1 exactly during E beats.
- Starvation override: BURST_MAX=16, MAX_WAIT=8, C requesting continuously, E requests at t0 -> wait_cnt saturates at 8 and E is granted within 9 cycles of t0.
- E preload then C read: E writes 5 to addr 8 and 12 to addr 12, then drops e_req; C loads both -> c_rdata=5 then 12, each with a one-cycle c_rvalid pulse.
- Release: the owner drops req with the other side idle -> state returns to IDLE next cycle; the next request waits one cycle for its grant.
